// File: rtl/sdram_test_reporter.sv
// rtl/sdram_test_reporter.sv - SDRAM tester status LEDs, error/pass counters and optional UART status frames
// The UART frame reporter is built only when UART_REPORT_EN is defined; otherwise uartTx idles high.
module sdram_test_reporter #(
    parameter int BAUD_DIV   = 434,
    parameter int BLINK_BITS = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready,
    input  logic        running,
    input  logic        error,
    output logic        ledRun,
    output logic        ledOk,
    output logic        ledErr,
    output logic [15:0] errCount,
    output logic [7:0]  passCount,
    output logic        uartTx
);

    logic                  prev_ready_q;
    logic                  prev_running_q;
    logic                  prev_error_q;
    logic [15:0]           err_count_q, err_count_d;
    logic [7:0]            pass_count_q, pass_count_d;
    logic                  sticky_q, sticky_d;
    logic [BLINK_BITS-1:0] hb_q;
    logic                  err_event;
    logic                  pass_event;
    logic                  unused_prev_ready;

    always_comb begin
        err_event    = ready && error && !prev_error_q;
        pass_event   = ready && !running && prev_running_q;
        err_count_d  = err_count_q;
        pass_count_d = pass_count_q;
        // Saturated count still leaves err_event visible to the sticky flag and reporter.
        if (err_event && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
        if (pass_event) begin
            pass_count_d = pass_count_q + 8'd1;
        end
        sticky_d = sticky_q | err_event;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_ready_q   <= 1'b0;
            prev_running_q <= 1'b0;
            prev_error_q   <= 1'b0;
            err_count_q    <= 16'd0;
            pass_count_q   <= 8'd0;
            sticky_q       <= 1'b0;
            hb_q           <= '0;
        end else begin
            prev_ready_q   <= ready;
            prev_running_q <= running;
            prev_error_q   <= error;
            err_count_q    <= err_count_d;
            pass_count_q   <= pass_count_d;
            sticky_q       <= sticky_d;
            hb_q           <= hb_q + BLINK_BITS'(1);
        end
    end

    assign ledRun            = running & ready;
    assign ledErr            = sticky_q;
    assign ledOk             = ready & ~sticky_q & hb_q[BLINK_BITS-1];
    assign errCount          = err_count_q;
    assign passCount         = pass_count_q;
    assign unused_prev_ready = prev_ready_q;

`ifdef UART_REPORT_EN
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int            CW        = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [31:0]   frame_q, frame_d;
    logic          pending_q, pending_d;
    logic          trigger;
    logic          bit_done;
    logic [7:0]    cur_byte;
    logic          uart_tx;

    always_comb begin
        trigger   = pass_event | (err_event & ~sticky_q);
        bit_done  = (baud_q == BAUD_LAST);
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        frame_d   = frame_q;
        pending_d = pending_q;
        if (state_q != IDLE) begin
            baud_d = bit_done ? '0 : baud_q + CW'(1);
            if (trigger) begin
                pending_d = 1'b1;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = START;
                    baud_d  = '0;
                    byte_d  = 2'd0;
                    frame_d = {8'h55, pass_count_d, err_count_d};
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (byte_q != 2'd3) begin
                        state_d = START;
                        byte_d  = byte_q + 2'd1;
                        frame_d = {frame_q[23:0], 8'h00};
                    end else if (pending_q || trigger) begin
                        // Merged triggers restart with a fresh snapshot of the counters.
                        state_d   = START;
                        byte_d    = 2'd0;
                        pending_d = 1'b0;
                        frame_d   = {8'h55, pass_count_d, err_count_d};
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= 3'd0;
            byte_q    <= 2'd0;
            frame_q   <= 32'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            frame_q   <= frame_d;
            pending_q <= pending_d;
        end
    end

    assign cur_byte = frame_q[31:24];

    always_comb begin
        uart_tx = 1'b1;
        case (state_q)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = cur_byte[bit_q];
            default: uart_tx = 1'b1;
        endcase
    end

    assign uartTx = uart_tx;
`else
    assign uartTx = 1'b1;
`endif

endmodule

// File: tb/tb_sdram_test_reporter.sv
// tb/tb_sdram_test_reporter.sv - directed bench with a cycle model of counters/LEDs and a UART frame checker
module tb_sdram_test_reporter;

    localparam int TB_BAUD  = 4;
    localparam int TB_BLINK = 4;

    logic        clock;
    logic        reset;
    logic        ready;
    logic        running;
    logic        error;
    logic        ledRun;
    logic        ledOk;
    logic        ledErr;
    logic [15:0] errCount;
    logic [7:0]  passCount;
    logic        uartTx;

    int total = 0;
    int bad   = 0;

    int m_err;
    int m_pass;
    int m_cyc;
    bit m_sticky;
    bit m_prev_err;
    bit m_prev_run;

    sdram_test_reporter #(
        .BAUD_DIV  (TB_BAUD),
        .BLINK_BITS(TB_BLINK)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ready    (ready),
        .running  (running),
        .error    (error),
        .ledRun   (ledRun),
        .ledOk    (ledOk),
        .ledErr   (ledErr),
        .errCount (errCount),
        .passCount(passCount),
        .uartTx   (uartTx)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts events from the input history, heartbeat is cycles since reset.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_err      <= 0;
            m_pass     <= 0;
            m_cyc      <= 0;
            m_sticky   <= 1'b0;
            m_prev_err <= 1'b0;
            m_prev_run <= 1'b0;
        end else begin
            m_cyc      <= m_cyc + 1;
            m_prev_err <= error;
            m_prev_run <= running;
            if (ready && error && !m_prev_err) begin
                m_sticky <= 1'b1;
                if (m_err < 65535) m_err <= m_err + 1;
            end
            if (ready && !running && m_prev_run) m_pass <= (m_pass + 1) % 256;
        end
    end

    always @(negedge clock) begin
        check("model_errCount", 32'(errCount), 32'(m_err));
        check("model_passCount", 32'(passCount), 32'(m_pass));
        check("model_ledErr", 32'(ledErr), 32'(m_sticky));
        check("model_ledRun", 32'(ledRun), 32'(ready & running));
        check("model_ledOk", 32'(ledOk), 32'(ready & !m_sticky & (((m_cyc >> (TB_BLINK - 1)) & 1) == 1)));
`ifndef UART_REPORT_EN
        check("model_uartTx_idle", 32'(uartTx), 32'd1);
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset   = 1'b1;
        ready   = 1'b0;
        running = 1'b0;
        error   = 1'b0;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic pass_pulse();
        running = 1'b1;
        tick(1);
        running = 1'b0;
        tick(1);
    endtask

    task automatic err_pulse();
        error = 1'b1;
        tick(1);
        error = 1'b0;
        tick(1);
    endtask

    task automatic check_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] b3, input bit idle_after);
        logic [31:0] word;
        logic [39:0] bits;
        bit          seen;
        word = {b0, b1, b2, b3};
        for (int j = 0; j < 4; j++) begin
            bits[10*j] = 1'b0;
            for (int i = 0; i < 8; i++) bits[10*j+1+i] = word[31-8*j-7+i];
            bits[10*j+9] = 1'b1;
        end
        seen = 1'b0;
        for (int w = 0; w < 400 && !seen; w++) begin
            @(negedge clock);
            if (uartTx === 1'b0) seen = 1'b1;
        end
        check("frame_start_seen", 32'(seen), 32'd1);
        if (seen) begin
            for (int k = 1; k < 40 * TB_BAUD; k++) begin
                @(negedge clock);
                check($sformatf("frame_bit_k%0d", k), 32'(uartTx), 32'(bits[k / TB_BAUD]));
            end
            if (idle_after) begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clock);
                    check("frame_idle_after", 32'(uartTx), 32'd1);
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        ready   = 1'b0;
        running = 1'b0;
        error   = 1'b0;
        tick(3);
        check("reset_errCount", 32'(errCount), 32'd0);
        check("reset_passCount", 32'(passCount), 32'd0);
        check("reset_ledErr", 32'(ledErr), 32'd0);
        check("reset_ledOk", 32'(ledOk), 32'd0);
        check("reset_uartTx", 32'(uartTx), 32'd1);
        reset = 1'b0;

        // Error held high for three cycles is a single event.
        do_reset();
        ready = 1'b1;
        tick(2);
        error = 1'b1;
        tick(1);
        check("err3_count_next", 32'(errCount), 32'd1);
        check("err3_ledErr_next", 32'(ledErr), 32'd1);
        check("err3_ledOk_next", 32'(ledOk), 32'd0);
        tick(2);
        error = 1'b0;
        tick(20);
        check("err3_count_held", 32'(errCount), 32'd1);
        check("err3_ledOk_held", 32'(ledOk), 32'd0);

        do_reset();
        ready = 1'b1;
        repeat (5) pass_pulse();
        check("pass5", 32'(passCount), 32'd5);
        repeat (255) pass_pulse();
        check("pass260_wrap", 32'(passCount), 32'd4);

        do_reset();
        repeat (10) begin
            err_pulse();
            pass_pulse();
        end
        check("notready_errCount", 32'(errCount), 32'd0);
        check("notready_passCount", 32'(passCount), 32'd0);
        check("notready_ledErr", 32'(ledErr), 32'd0);

        do_reset();
        ready   = 1'b1;
        running = 1'b1;
        tick(1);
        running = 1'b0;
        error   = 1'b1;
        tick(1);
        check("simul_errCount", 32'(errCount), 32'd1);
        check("simul_passCount", 32'(passCount), 32'd1);
`ifdef UART_REPORT_EN
        check_frame(8'h55, 8'h01, 8'h00, 8'h01, 1'b1);
`endif
        error = 1'b0;

        do_reset();
        ready = 1'b1;
        repeat (65535) err_pulse();
        check("sat_at_ffff", 32'(errCount), 32'h0000_FFFF);
        repeat (5) err_pulse();
        check("sat_held_65540", 32'(errCount), 32'h0000_FFFF);
        check("sat_ledErr", 32'(ledErr), 32'd1);

`ifdef UART_REPORT_EN
        do_reset();
        ready = 1'b1;
        pass_pulse();
        check_frame(8'h55, 8'h01, 8'h00, 8'h00, 1'b1);

        do_reset();
        ready = 1'b1;
        pass_pulse();
        fork
            check_frame(8'h55, 8'h01, 8'h00, 8'h00, 1'b0);
            begin
                tick(20);
                pass_pulse();
                tick(10);
                pass_pulse();
            end
        join
        check_frame(8'h55, 8'h03, 8'h00, 8'h00, 1'b1);
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            check("no_third_frame", 32'(uartTx), 32'd1);
        end

        // Cycle 26 of a frame is data bit 5 of 0x55, which is low.
        do_reset();
        ready = 1'b1;
        pass_pulse();
        tick(26);
        check("midframe_low", 32'(uartTx), 32'd0);
        reset = 1'b1;
        #1;
        check("midframe_reset_high", 32'(uartTx), 32'd1);
        tick(1);
        reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            check("abandoned_frame", 32'(uartTx), 32'd1);
        end
`endif

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_test_reporter.md
SDRAM_TEST_REPORTER -- requirements
Module: sdram_test_reporter

Interface
REQ-001 The module SHALL have parameter BAUD_DIV, default 434, meaning clocks per UART bit (50 MHz / 115200).
REQ-002 The module SHALL have parameter BLINK_BITS, default 24, meaning the heartbeat counter width; its MSB drives the blink.
REQ-003 The module SHALL have port clock, input, 1 bit: system clock, all logic on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port ready, input, 1 bit: the upstream SDRAM tester has finished init.
REQ-006 The module SHALL have port running, input, 1 bit: the upstream pass indicator, which toggles once per half address sweep.
REQ-007 The module SHALL have port error, input, 1 bit: the upstream read-compare mismatch flag.
REQ-008 The module SHALL have port ledRun, output, 1 bit: test activity.
REQ-009 The module SHALL have port ledOk, output, 1 bit: blinking heartbeat while error-free.
REQ-010 The module SHALL have port ledErr, output, 1 bit: sticky error indicator.
REQ-011 The module SHALL have port errCount, output, 16 bits: count of error events.
REQ-012 The module SHALL have port passCount, output, 8 bits: count of completed passes.
REQ-013 The module SHALL have port uartTx, output, 1 bit: serial status line, 8N1, idle high.

Function
REQ-014 The module SHALL register ready, running and error once (prevReady, prevRunning, prevError) for edge detection, with no further input synchronisation because the inputs share the clock domain.
REQ-015 An error event SHALL be defined as ready=1 and error=1 and prevError=0; while ready=1, every error event SHALL increment errCount by 1.
REQ-016 errCount SHALL saturate at 0xFFFF; further error events leave it unchanged but still count as events for REQ-017 and REQ-022.
REQ-017 stickyErr SHALL be set on the first error event and cleared only by reset; ledErr SHALL equal stickyErr.
REQ-018 A pass event SHALL be defined as ready=1 and running=0 and prevRunning=1; each pass event SHALL increment passCount, which wraps from 255 to 0.
REQ-019 While ready=0, the module SHALL detect no events, and both counters SHALL hold.
REQ-020 ledRun SHALL equal running AND ready.
REQ-021 The heartbeat counter SHALL free-run and wrap; ledOk SHALL equal ready AND NOT stickyErr AND heartbeat MSB.
REQ-022 An error event and a pass event in the same cycle SHALL both be counted in that cycle.
REQ-023 errCount and passCount SHALL update in the cycle after the input edge is visible; the outputs are registered.

Reset
REQ-024 reset SHALL asynchronously force errCount=0, passCount=0, stickyErr=0, heartbeat=0, all prev registers=0, uartTx=1 and UART state IDLE with pending=0.
REQ-025 If reset is asserted mid-frame, uartTx SHALL return high immediately and the frame SHALL be abandoned without resumption.
REQ-026 After reset deasserts, the module SHALL resume operation on the first clock edge.

Configuration
REQ-027 With macro UART_REPORT_EN defined, the module SHALL include the UART reporter described in REQ-028 to REQ-032.
REQ-028 The reporter SHALL trigger a frame on each pass event and on the first error event only, and a simultaneous pass event and first error event SHALL trigger a single frame.
REQ-029 Each frame SHALL be 4 bytes: 0x55, passCount, errCount[15:8], errCount[7:0]; the module SHALL snapshot these values on the cycle the frame starts, taking the post-increment values.
REQ-030 Each byte SHALL be sent as a start bit (0), 8 data bits LSB first and a stop bit (1), each bit lasting BAUD_DIV clocks, with bytes back-to-back; the state machine SHALL use states IDLE -> START -> DATA -> STOP -> (next byte START | IDLE).
REQ-031 A trigger during an active frame SHALL set a one-deep pending flag, and additional triggers SHALL merge into it; at frame end, if pending is set, the module SHALL clear it and start a new frame with a fresh snapshot.
REQ-032 Without UART_REPORT_EN, uartTx SHALL be constant 1 and the module SHALL synthesise no reporter logic; the LEDs and counters SHALL be unaffected.

Verification
REQ-033 The bench SHALL check: reset, then ready=1 with error pulsed high for 3 cycles -> errCount=1, ledErr=1, ledOk=0 from the next cycle.
REQ-034 The bench SHALL check: 5 running 1->0 transitions with ready=1 -> passCount=5; 260 such transitions -> passCount=4.
REQ-035 The bench SHALL check: with ready=0, error pulses and running toggles -> counters remain 0 and ledErr remains 0.
REQ-036 The bench SHALL check: 65540 error pulses -> errCount=0xFFFF held.
REQ-037 The bench SHALL check (UART_REPORT_EN, BAUD_DIV=4): one pass event -> uartTx carries bytes 0x55, 0x01, 0x00, 0x00 with 40 bits over 160 clocks, then stays high.
REQ-038 The bench SHALL check (UART_REPORT_EN): two pass events during a frame -> exactly one follow-up frame carrying passCount=3; reset asserted mid-frame -> uartTx=1 immediately.
